// File: rtl/mips_mem_pkg.sv
// Shared types for the MIPS load/store + writeback stage.
//   mem_size_e  : access size decoded from the 2-bit ex_size field
//   ls_state_e  : load/store sequencer states (IDLE, RMW)
//   p_reg_t     : pipeline register between accept and writeback
//   MemWidth / MemDepth : default data width and word-address width
package mips_mem_pkg;

  localparam int unsigned MemWidth = 32;
  localparam int unsigned MemDepth = 16;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_e;

  typedef enum logic {
    IDLE = 1'b0,
    RMW  = 1'b1
  } ls_state_e;

  typedef struct packed {
    logic        reg_write;
    logic [4:0]  rd;
    logic        mem_read;
    mem_size_e   size;
    logic        zero_ext;
    logic [1:0]  offset;
    logic [31:0] ex_addr;
  } p_reg_t;

  // Encoding 3 is not a real size; it behaves as a word access.
  function automatic mem_size_e decode_size(input logic [1:0] raw);
    case (raw)
      2'd0:    return SZ_BYTE;
      2'd1:    return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  // Byte offset forced to the natural alignment of the access size.
  function automatic logic [1:0] align_offset(input mem_size_e size, input logic [1:0] byte_off);
    case (size)
      SZ_BYTE: return byte_off;
      SZ_HALF: return {byte_off[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational sub-word lane logic, big-endian (offset 0 = most significant lane).
//   Load side : load_word_i -> lane selected by load_size_i/load_offset_i,
//               sign- or zero-extended (load_zero_ext_i) onto load_data_o.
//   Store side: store_word_i with the addressed lane replaced by the low
//               byte/half of store_data_i, driven on merged_o.
module load_store_align
  import mips_mem_pkg::*;
#(
  parameter int unsigned WIDTH = MemWidth
) (
  input  mem_size_e        load_size_i,
  input  logic [1:0]       load_offset_i,
  input  logic             load_zero_ext_i,
  input  logic [WIDTH-1:0] load_word_i,
  output logic [WIDTH-1:0] load_data_o,
  input  mem_size_e        store_size_i,
  input  logic [1:0]       store_offset_i,
  input  logic [15:0]      store_data_i,
  input  logic [WIDTH-1:0] store_word_i,
  output logic [WIDTH-1:0] merged_o
);

  int unsigned ld_byte_lsb, ld_half_lsb, st_byte_lsb, st_half_lsb;
  logic [7:0]  lane8;
  logic [15:0] lane16;

  always_comb begin
    ld_byte_lsb = WIDTH - 8 - 8 * 32'(load_offset_i);
    ld_half_lsb = WIDTH - 16 - 8 * 32'(load_offset_i);
    lane8       = load_word_i[ld_byte_lsb +: 8];
    lane16      = load_word_i[ld_half_lsb +: 16];
    case (load_size_i)
      SZ_BYTE: load_data_o = {{(WIDTH - 8){~load_zero_ext_i & lane8[7]}}, lane8};
      SZ_HALF: load_data_o = {{(WIDTH - 16){~load_zero_ext_i & lane16[15]}}, lane16};
      default: load_data_o = load_word_i;
    endcase
  end

  always_comb begin
    st_byte_lsb = WIDTH - 8 - 8 * 32'(store_offset_i);
    st_half_lsb = WIDTH - 16 - 8 * 32'(store_offset_i);
    merged_o    = store_word_i;
    case (store_size_i)
      SZ_BYTE: merged_o[st_byte_lsb +: 8] = store_data_i[7:0];
      SZ_HALF: merged_o[st_half_lsb +: 16] = store_data_i;
      default: merged_o = store_word_i;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MIPS load/store + writeback stage between execute and a word-wide data memory.
// Memory has no byte enables, so byte/half stores are done as read-modify-write
// (one extra stall cycle). Loads and ALU results reach wb_* two cycles after accept.
//   ex_*      : execute-stage instruction (accepted when ex_valid & ~stall)
//   stall     : upstream hold, high while the RMW write cycle is in progress
//   MemRead/MemWrite/Address/WD/RD : data memory interface (RD valid 1 cycle after MemRead)
//   wb_*      : register-file write port; wb_misalign pulses on trapped accesses
// Optional build macro MEMWB_MISALIGN_TRAP_EN: misaligned half/word accesses are
// suppressed and flagged instead of being silently aligned.
module mem_wb_stage
  import mips_mem_pkg::*;
#(
  parameter int unsigned WIDTH = MemWidth,
  parameter int unsigned DEPTH = MemDepth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic             ex_mem_write,
  input  logic [1:0]       ex_size,
  input  logic             ex_unsigned,
  input  logic [31:0]      ex_addr,
  input  logic [WIDTH-1:0] ex_store_data,
  input  logic             ex_reg_write,
  input  logic [4:0]       ex_rd,
  output logic             stall,
  output logic             MemRead,
  output logic             MemWrite,
  output logic [DEPTH-1:0] Address,
  output logic [WIDTH-1:0] WD,
  input  logic [WIDTH-1:0] RD,
  output logic             wb_reg_write,
  output logic [4:0]       wb_rd,
  output logic [WIDTH-1:0] wb_data,
  output logic             wb_misalign
);

  ls_state_e        state_q, state_d;
  logic             accept, is_load, is_store, misalign, rmw_start;
  mem_size_e        size;
  logic [1:0]       offset;
  p_reg_t           p_q, p_d;
  logic [DEPTH-1:0] rmw_addr_q;
  logic [1:0]       rmw_off_q;
  mem_size_e        rmw_size_q;
  logic [15:0]      rmw_data_q;
  logic [WIDTH-1:0] load_data, merged;
  logic             wb_reg_write_q;
  logic [4:0]       wb_rd_q;
  logic [WIDTH-1:0] wb_data_q;

  assign stall    = (state_q == RMW);
  // Gating with rst keeps every memory control low while reset is held.
  assign accept   = ex_valid & ~stall & ~rst;
  // A store wins over a simultaneous read request.
  assign is_store = ex_mem_write;
  assign is_load  = ex_mem_read & ~ex_mem_write;
  assign size     = decode_size(ex_size);
  assign offset   = align_offset(size, ex_addr[1:0]);

`ifdef MEMWB_MISALIGN_TRAP_EN
  logic p_mis_q, wb_mis_q;

  assign misalign = (is_load | is_store) &
                    (((size == SZ_HALF) & ex_addr[0]) |
                     ((size == SZ_WORD) & (ex_addr[1:0] != 2'b00)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_mis_q  <= 1'b0;
      wb_mis_q <= 1'b0;
    end else begin
      p_mis_q  <= accept & misalign;
      wb_mis_q <= p_mis_q;
    end
  end

  assign wb_misalign = wb_mis_q;
`else
  assign misalign    = 1'b0;
  assign wb_misalign = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    Address   = '0;
    WD        = '0;
    p_d       = '0;
    rmw_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          p_d.reg_write = ex_reg_write & ~misalign;
          p_d.rd        = ex_rd;
          p_d.mem_read  = is_load & ~misalign;
          p_d.size      = size;
          p_d.zero_ext  = ex_unsigned;
          p_d.offset    = offset;
          p_d.ex_addr   = ex_addr;
          if (!misalign && (is_load || is_store)) begin
            Address = ex_addr[DEPTH+1:2];
            if (is_store && size == SZ_WORD) begin
              MemWrite = 1'b1;
              WD       = ex_store_data;
            end else if (is_store) begin
              // Fetch the old word now; the merge and write happen in RMW.
              MemRead   = 1'b1;
              rmw_start = 1'b1;
              state_d   = RMW;
              p_d       = '0;
            end else begin
              MemRead = 1'b1;
            end
          end
        end
      end
      RMW: begin
        MemWrite = 1'b1;
        Address  = rmw_addr_q;
        WD       = merged;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      p_q        <= '0;
      rmw_addr_q <= '0;
      rmw_off_q  <= 2'b00;
      rmw_size_q <= SZ_BYTE;
      rmw_data_q <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      if (rmw_start) begin
        rmw_addr_q <= ex_addr[DEPTH+1:2];
        rmw_off_q  <= offset;
        rmw_size_q <= size;
        rmw_data_q <= ex_store_data[15:0];
      end
    end
  end

  load_store_align #(
    .WIDTH(WIDTH)
  ) u_align (
    .load_size_i    (p_q.size),
    .load_offset_i  (p_q.offset),
    .load_zero_ext_i(p_q.zero_ext),
    .load_word_i    (RD),
    .load_data_o    (load_data),
    .store_size_i   (rmw_size_q),
    .store_offset_i (rmw_off_q),
    .store_data_i   (rmw_data_q),
    .store_word_i   (RD),
    .merged_o       (merged)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_reg_write_q <= 1'b0;
      wb_rd_q        <= '0;
      wb_data_q      <= '0;
    end else begin
      wb_reg_write_q <= p_q.reg_write;
      wb_rd_q        <= p_q.rd;
      wb_data_q      <= p_q.mem_read ? load_data : WIDTH'(p_q.ex_addr);
    end
  end

  assign wb_reg_write = wb_reg_write_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

  localparam int unsigned W = 32;
  localparam int unsigned D = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         ex_valid, ex_mem_read, ex_mem_write, ex_unsigned, ex_reg_write;
  logic [1:0]   ex_size;
  logic [31:0]  ex_addr;
  logic [W-1:0] ex_store_data;
  logic [4:0]   ex_rd;
  logic         stall, MemRead, MemWrite;
  logic [D-1:0] Address;
  logic [W-1:0] WD, RD;
  logic         wb_reg_write, wb_misalign;
  logic [4:0]   wb_rd;
  logic [W-1:0] wb_data;

  always #5 clk = ~clk;

  mem_wb_stage #(.WIDTH(W), .DEPTH(D)) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_valid),
    .ex_mem_read  (ex_mem_read),
    .ex_mem_write (ex_mem_write),
    .ex_size      (ex_size),
    .ex_unsigned  (ex_unsigned),
    .ex_addr      (ex_addr),
    .ex_store_data(ex_store_data),
    .ex_reg_write (ex_reg_write),
    .ex_rd        (ex_rd),
    .stall        (stall),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .Address      (Address),
    .WD           (WD),
    .RD           (RD),
    .wb_reg_write (wb_reg_write),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .wb_misalign  (wb_misalign)
  );

  // Word memory model: sync write, registered read; preload port for setup.
  logic [W-1:0] mem [65536];
  logic         pl_en;
  logic [15:0]  pl_addr;
  logic [W-1:0] pl_data;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (MemWrite) mem[Address] <= WD;
    if (MemRead) RD <= mem[Address];
  end

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else passed++;
  endtask

  typedef struct {
    logic        v, r, w;
    logic [1:0]  sz;
    logic        u;
    logic [31:0] addr, sd;
    logic        rw;
    logic [4:0]  rd;
    logic        e_mr, e_mw;
    logic [15:0] e_addr;
    logic [31:0] e_wd;
    logic        w_rw;
    logic [4:0]  w_rd;
    logic [31:0] w_data;
    logic        w_mis;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic v, r, w, input logic [1:0] sz, input logic u,
                              input logic [31:0] addr, sd, input logic rw, input logic [4:0] rd,
                              input logic e_mr, e_mw, input logic [15:0] e_addr,
                              input logic [31:0] e_wd, input logic w_rw,
                              input logic [4:0] w_rd, input logic [31:0] w_data,
                              input logic w_mis);
    vec_t t;
    t.v = v; t.r = r; t.w = w; t.sz = sz; t.u = u; t.addr = addr; t.sd = sd;
    t.rw = rw; t.rd = rd; t.e_mr = e_mr; t.e_mw = e_mw; t.e_addr = e_addr; t.e_wd = e_wd;
    t.w_rw = w_rw; t.w_rd = w_rd; t.w_data = w_data; t.w_mis = w_mis;
    return t;
  endfunction

  task automatic drive(input logic v, r, w, input logic [1:0] sz, input logic u,
                       input logic [31:0] addr, sd, input logic rw, input logic [4:0] rd);
    ex_valid = v; ex_mem_read = r; ex_mem_write = w; ex_size = sz; ex_unsigned = u;
    ex_addr = addr; ex_store_data = sd; ex_reg_write = rw; ex_rd = rd;
  endtask

  task automatic bubble();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " stall"}, {31'b0, stall}, 32'h0);
    chk({tag, " MemRead"}, {31'b0, MemRead}, 32'h0);
    chk({tag, " MemWrite"}, {31'b0, MemWrite}, 32'h0);
    chk({tag, " Address"}, {16'b0, Address}, 32'h0);
    chk({tag, " WD"}, WD, 32'h0);
    chk({tag, " wb_reg_write"}, {31'b0, wb_reg_write}, 32'h0);
    chk({tag, " wb_rd"}, {27'b0, wb_rd}, 32'h0);
    chk({tag, " wb_data"}, wb_data, 32'h0);
    chk({tag, " wb_misalign"}, {31'b0, wb_misalign}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hits, hit_cyc;
    vec_t t;

    rst = 1'b1;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    bubble();

    @(negedge clk);
    chk_all_zero("reset");

    // Preload while reset is held.
    next_cycle();
    pl_en = 1'b1; pl_addr = 16'd0; pl_data = 32'hCAFEF00D; next_cycle();
    pl_addr = 16'd1; pl_data = 32'h80FF7F01; next_cycle();
    pl_addr = 16'd2; pl_data = 32'h11223344; next_cycle();
    pl_addr = 16'd5; pl_data = 32'h55667788; next_cycle();
    pl_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    next_cycle();

    // ---- table: single-cycle instructions, no RMW ----
    vecs.push_back(mk(1, 0, 1, 2, 0, 32'h10, 32'hDEADBEEF, 0, 0,  0, 1, 16'd4, 32'hDEADBEEF,
                      0, 0, 32'h10, 0));
    vecs.push_back(mk(1, 1, 0, 2, 0, 32'h10, 0, 1, 5,  1, 0, 16'd4, 0,  1, 5, 32'hDEADBEEF, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 32'h4, 0, 1, 6,   1, 0, 16'd1, 0,  1, 6, 32'hFFFFFF80, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 32'h4, 0, 1, 7,   1, 0, 16'd1, 0,  1, 7, 32'h00000080, 0));
    vecs.push_back(mk(1, 1, 0, 1, 0, 32'h6, 0, 1, 8,   1, 0, 16'd1, 0,  1, 8, 32'h00007F01, 0));
    vecs.push_back(mk(1, 1, 0, 1, 1, 32'h4, 0, 1, 9,   1, 0, 16'd1, 0,  1, 9, 32'h000080FF, 0));
    vecs.push_back(mk(1, 1, 0, 1, 0, 32'h4, 0, 1, 10,  1, 0, 16'd1, 0,  1, 10, 32'hFFFF80FF, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 32'h7, 0, 1, 11,  1, 0, 16'd1, 0,  1, 11, 32'h00000001, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 32'h5, 0, 1, 12,  1, 0, 16'd1, 0,  1, 12, 32'hFFFFFFFF, 0));
    vecs.push_back(mk(1, 0, 0, 2, 0, 32'h55, 0, 1, 3,  0, 0, 16'd0, 0,  1, 3, 32'h00000055, 0));
    vecs.push_back(mk(1, 0, 0, 2, 0, 32'h1234, 0, 1, 0, 0, 0, 16'd0, 0, 1, 0, 32'h00001234, 0));
    vecs.push_back(mk(1, 1, 1, 2, 0, 32'hC, 32'h01020304, 0, 0,  0, 1, 16'd3, 32'h01020304,
                      0, 0, 32'h0000000C, 0));
    vecs.push_back(mk(1, 1, 0, 2, 0, 32'hC, 0, 1, 13,  1, 0, 16'd3, 0,  1, 13, 32'h01020304, 0));
    vecs.push_back(mk(0, 1, 0, 2, 0, 32'h4, 0, 1, 14,  0, 0, 16'd0, 0,  0, 0, 32'h0, 0));
    vecs.push_back(mk(1, 1, 0, 3, 0, 32'h4, 0, 1, 15,  1, 0, 16'd1, 0,  1, 15, 32'h80FF7F01, 0));
`ifdef MEMWB_MISALIGN_TRAP_EN
    vecs.push_back(mk(1, 1, 0, 2, 0, 32'h3, 0, 1, 16,  0, 0, 16'd0, 0,  0, 16, 32'h00000003, 1));
    vecs.push_back(mk(1, 1, 0, 1, 0, 32'h5, 0, 1, 17,  0, 0, 16'd0, 0,  0, 17, 32'h00000005, 1));
`else
    vecs.push_back(mk(1, 1, 0, 2, 0, 32'h3, 0, 1, 16,  1, 0, 16'd0, 0,  1, 16, 32'hCAFEF00D, 0));
    vecs.push_back(mk(1, 1, 0, 1, 0, 32'h5, 0, 1, 17,  1, 0, 16'd1, 0,  1, 17, 32'hFFFF80FF, 0));
`endif

    for (int i = 0; i < vecs.size() + 2; i++) begin
      if (i < vecs.size()) begin
        t = vecs[i];
        drive(t.v, t.r, t.w, t.sz, t.u, t.addr, t.sd, t.rw, t.rd);
      end else begin
        bubble();
      end
      @(negedge clk);
      if (i < vecs.size()) begin
        t = vecs[i];
        chk($sformatf("row%0d stall", i), {31'b0, stall}, 32'h0);
        chk($sformatf("row%0d MemRead", i), {31'b0, MemRead}, {31'b0, t.e_mr});
        chk($sformatf("row%0d MemWrite", i), {31'b0, MemWrite}, {31'b0, t.e_mw});
        if (t.e_mr || t.e_mw) chk($sformatf("row%0d Address", i), {16'b0, Address}, {16'b0, t.e_addr});
        if (t.e_mw) chk($sformatf("row%0d WD", i), WD, t.e_wd);
      end
      if (i >= 2) begin
        t = vecs[i-2];
        chk($sformatf("row%0d wb_reg_write", i - 2), {31'b0, wb_reg_write}, {31'b0, t.w_rw});
        chk($sformatf("row%0d wb_rd", i - 2), {27'b0, wb_rd}, {27'b0, t.w_rd});
        chk($sformatf("row%0d wb_data", i - 2), wb_data, t.w_data);
        chk($sformatf("row%0d wb_misalign", i - 2), {31'b0, wb_misalign}, {31'b0, t.w_mis});
      end
      next_cycle();
    end

    // ---- byte store RMW, then lw of the same word held through the stall ----
    drive(1, 0, 1, 2'd0, 0, 32'hA, 32'h123456AB, 0, 0);
    @(negedge clk);
    chk("sb issue stall", {31'b0, stall}, 32'h0);
    chk("sb issue MemRead", {31'b0, MemRead}, 32'h1);
    chk("sb issue MemWrite", {31'b0, MemWrite}, 32'h0);
    chk("sb issue Address", {16'b0, Address}, 32'h2);
    next_cycle();
    drive(1, 1, 0, 2'd2, 0, 32'h8, 32'h0, 1, 20);
    @(negedge clk);
    chk("sb rmw stall", {31'b0, stall}, 32'h1);
    chk("sb rmw MemWrite", {31'b0, MemWrite}, 32'h1);
    chk("sb rmw MemRead", {31'b0, MemRead}, 32'h0);
    chk("sb rmw Address", {16'b0, Address}, 32'h2);
    chk("sb rmw WD", WD, 32'h1122AB44);
    next_cycle();
    @(negedge clk);
    chk("sb after stall", {31'b0, stall}, 32'h0);
    chk("lw accept MemRead", {31'b0, MemRead}, 32'h1);
    chk("lw accept Address", {16'b0, Address}, 32'h2);
    chk("sb bubble wb_reg_write", {31'b0, wb_reg_write}, 32'h0);
    chk("sb mem word2", mem[2], 32'h1122AB44);
    next_cycle();
    bubble();
    @(negedge clk);
    chk("sb stall once", {31'b0, stall}, 32'h0);
    chk("stall bubble wb_reg_write", {31'b0, wb_reg_write}, 32'h0);
    next_cycle();
    @(negedge clk);
    chk("lw after sb wb_reg_write", {31'b0, wb_reg_write}, 32'h1);
    chk("lw after sb wb_rd", {27'b0, wb_rd}, 32'd20);
    chk("lw after sb wb_data", wb_data, 32'h1122AB44);
    next_cycle();

    // ---- sh followed by an ALU op held through the stall ----
    hits = 0;
    hit_cyc = -1;
    for (int c = 0; c < 7; c++) begin
      if (c == 0) drive(1, 0, 1, 2'd1, 0, 32'h2, 32'h0000BEEF, 0, 0);
      else if (c <= 2) drive(1, 0, 0, 2'd2, 0, 32'h55, 32'h0, 1, 3);
      else bubble();
      @(negedge clk);
      if (c == 1) begin
        chk("sh rmw stall", {31'b0, stall}, 32'h1);
        chk("sh rmw WD", WD, 32'hCAFEBEEF);
      end
      if (c == 2) chk("sh released stall", {31'b0, stall}, 32'h0);
      if (wb_reg_write && wb_rd == 5'd3 && wb_data == 32'h55) begin
        hits++;
        hit_cyc = c;
      end
      next_cycle();
    end
    chk("alu after sh count", hits, 32'd1);
    chk("alu after sh cycle", hit_cyc, 32'd4);
    chk("sh mem word0", mem[0], 32'hCAFEBEEF);

    // ---- reset during the RMW cycle ----
    drive(1, 0, 1, 2'd0, 0, 32'h14, 32'h00000099, 0, 0);
    next_cycle();
    drive(1, 1, 0, 2'd2, 0, 32'h4, 32'h0, 1, 21);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("rst mid-rmw");
    next_cycle();
    @(negedge clk);
    rst = 1'b0;
    bubble();
    next_cycle();
    @(negedge clk);
    chk("rst mid-rmw mem word5", mem[5], 32'h55667788);
    chk("rst mid-rmw idle stall", {31'b0, stall}, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
